bin2bcd_conv: RTL and testbench
===============================

// Module: bin2bcd_conv
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3, "double dabble") placed directly
//  downstream of the Fibonacci FSMD: takes its 16-bit result f and produces 5 decimal digits
//  for the display/readout stage. Same start/ready/done_tick handshake as the Fibonacci
//  unit, so the producer's done_tick can drive start directly.
// PARAMETERS
//  WIDTH   16  binary input width; also the number of op-state iterations
//  DIGITS  5   BCD digits out; must satisfy 10**DIGITS > 2**WIDTH-1
// PORTS
//  clk        in   1           clock, rising edge
//  reset      in   1           asynchronous, active-high; clears all state
//  start      in   1           request; sampled only while ready=1
//  bin        in   WIDTH       binary value; captured on the accepted start cycle only
//  ready      out  1           high in idle state (combinational from state)
//  done_tick  out  1           one-cycle pulse in done state
//  bcd        out  4*DIGITS    packed digits, [3:0]=units ... [4*DIGITS-1 -: 4]=most significant
// BEHAVIOUR
//  Reset: state=idle; p2s (shift reg), bcd digit regs, n counter all 0; ready=1, done_tick=0, bcd=0.
//  States: idle(2'b00), op(2'b01), done(2'b10); any other encoding -> idle next cycle.
//  idle: ready=1. If start: p2s<=bin, all digits<=0, n<=WIDTH, -> op. Else hold all regs.
//  op (one iteration per cycle):
//   - adjust: every digit d in the current registers becomes d+3 if d>4, else d (4-bit add).
//   - shift: {digits,p2s} <= {adjusted digits,p2s} << 1; p2s MSB enters bit 0 of digit 0;
//     most significant digit's carry-out is discarded.
//   - n<=n-1; when n==1 in this cycle -> done. The op state lasts exactly WIDTH cycles.
//  done: done_tick=1 for exactly one cycle, ready=0, -> idle. Registers hold.
//  Latency: start accepted at edge k -> op for edges k+1..k+WIDTH -> done_tick high during
//   the cycle after edge k+WIDTH; bcd is final when done_tick rises.
//  Output hold: bcd is driven straight from the digit registers. It holds the last result
//   until the next accepted start, then clears to 0. Intermediate values are visible during
//   op; consumers qualify bcd with done_tick or ready.
//  start while ready=0 (op or done) is ignored. No queueing.
//  Back-to-back: start in the idle cycle right after done is accepted normally.
//  bin changes after capture do not affect the result.
//  Reset mid-operation aborts immediately. No partial result is kept, and the next start
//   behaves as after power-up.
//  n is clog2(WIDTH+1) bits wide and never wraps: it is only decremented in op while n>=1.
// STRUCTURE
//  Shared package fsmd_pkg: state localparams IDLE/OP/DONE (2-bit). The Fibonacci unit uses
//   the same encoding.
//  One sub-module, bcd_add3: combinational 4-bit in/out, (d>4)?d+3:d. Instantiated DIGITS
//   times via generate.
//  Top: one async-reset register block (state, p2s, digits, n) and one combinational
//   next-state/output block with defaults at the top.
// TESTING
//  1. bin=0, start 1 cycle -> done_tick exactly 17 cycles after the start edge; bcd=20'h00000;
//     ready low for 17 cycles.
//  2. bin=16'hFFFF -> bcd=20'h65535; bin=46368 (fib 24) -> 20'h46368; bin=9999 -> 20'h09999.
//  3. Pulse start again in the idle cycle after done_tick with bin=9 -> accepted; bcd reads 0
//     during op, then 20'h00009 at done_tick.
//  4. Hold start=1 and change bin to 16'h1234 during op of a bin=100 conversion -> exactly
//     one done_tick with bcd=20'h00100. The held start then begins a new conversion from idle.
//  5. Assert reset for 1 cycle at op iteration 8 of bin=12345 -> ready=1, done_tick=0, bcd=0
//     asynchronously. A new conversion of 1234 then yields 20'h01234.
//  6. Randomised sweep: 1000 values, checked against a $sformat decimal reference; latency
//     is always 17 cycles.

Source files
------------

// File: rtl/fsmd_pkg.sv
// Shared FSMD definitions.
// Holds the control-state encoding used by the Fibonacci unit and by the
// binary-to-BCD converter. Both units run the same idle/op/done handshake,
// so sharing the encoding keeps the two controllers interchangeable.
package fsmd_pkg;

  // Control state encoding (2 bits); the fourth code is illegal and recovers to IDLE.
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] OP   = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

endpackage : fsmd_pkg

// File: rtl/bcd_add3.sv
// One BCD digit correction step of the shift-and-add-3 algorithm.
// A digit above 4 would become 10 or more after the next left shift, so
// 3 is added first to make the shift carry into the next digit instead.
// Ports:
//   i_d  in   4  current digit value
//   o_d  out  4  corrected digit, (i_d > 4) ? i_d + 3 : i_d
module bcd_add3 (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);

  // Valid digits stay at or below 12 after the add, so 4-bit wrap cannot occur.
  assign o_d = (i_d > 4'd4) ? (i_d + 4'd3) : i_d;

endmodule : bcd_add3

// File: rtl/bin2bcd_conv.sv
// Sequential binary-to-BCD converter (double dabble).
// Accepts a WIDTH-bit binary value on a start/ready handshake and, WIDTH op
// cycles later, presents DIGITS packed BCD digits together with a one-cycle
// done_tick. The producer's done_tick may drive start directly.
// Ports:
//   clk        in   1          clock, rising edge
//   reset      in   1          asynchronous active-high reset
//   start      in   1          conversion request, honoured only while ready=1
//   bin        in   WIDTH      binary value, captured on the accepted start cycle
//   ready      out  1          high while idle
//   done_tick  out  1          one-cycle pulse when the result is final
//   bcd        out  4*DIGITS   digits, [3:0]=units ... top nibble=most significant
module bin2bcd_conv
  import fsmd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  ready,
  output logic                  done_tick,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int              NW     = $clog2(WIDTH + 1);
  localparam logic [NW-1:0]   N_INIT = NW'(WIDTH);
  localparam logic [NW-1:0]   N_ONE  = NW'(1);
  localparam logic [NW-1:0]   N_ZERO = NW'(0);

  logic [1:0]            r_state;
  logic [WIDTH-1:0]      r_p2s;
  logic [4*DIGITS-1:0]   r_digits;
  logic [NW-1:0]         r_n;

  logic [1:0]            w_state_nxt;
  logic [WIDTH-1:0]      w_p2s_nxt;
  logic [4*DIGITS-1:0]   w_digits_nxt;
  logic [NW-1:0]         w_n_nxt;
  logic [4*DIGITS-1:0]   w_adj;

  // Per-digit add-3 correction applied to the current digit registers.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_d (r_digits[4*g +: 4]),
      .o_d (w_adj[4*g +: 4])
    );
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_p2s    <= '0;
      r_digits <= '0;
      r_n      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_p2s    <= w_p2s_nxt;
      r_digits <= w_digits_nxt;
      r_n      <= w_n_nxt;
    end
  end

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_p2s_nxt    = r_p2s;
    w_digits_nxt = r_digits;
    w_n_nxt      = r_n;
    ready        = 1'b0;
    done_tick    = 1'b0;

    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          w_p2s_nxt    = bin;
          w_digits_nxt = '0;
          w_n_nxt      = N_INIT;
          w_state_nxt  = OP;
        end else begin
          w_state_nxt  = IDLE;
        end
      end

      OP: begin
        // Shift the corrected digits left by one; the next binary bit (MSB first)
        // enters the units digit and the top digit's carry-out is dropped.
        w_digits_nxt = {w_adj[4*DIGITS-2:0], r_p2s[WIDTH-1]};
        w_p2s_nxt    = {r_p2s[WIDTH-2:0], 1'b0};
        if (r_n != N_ZERO) begin
          w_n_nxt = r_n - N_ONE;
        end else begin
          w_n_nxt = r_n;
        end
        // n can only be 0 here after an upset; finish rather than loop forever.
        if (r_n <= N_ONE) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = OP;
        end
      end

      DONE: begin
        done_tick   = 1'b1;
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Digits drive the output directly; intermediate values are visible during op.
  assign bcd = r_digits;

endmodule : bin2bcd_conv

// File: tb/tb_bin2bcd_conv.sv
module tb_bin2bcd_conv;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int LAT    = 17;  // done_tick falls in the 17th cycle after the start edge

  logic                clk;
  logic                reset;
  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                ready;
  logic                done_tick;
  logic [4*DIGITS-1:0] bcd;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_done = 0;
  int n_push = 0;

  typedef struct {
    logic [19:0] exp;
    int          start_cyc;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [15:0] bin;
    logic [19:0] exp;
  } vec_t;
  vec_t vecs[8];

  bin2bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bin       (bin),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd       (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input logic [15:0] v);
    string s;
    logic [19:0] r;
    byte c;
    s = $sformatf("%05d", v);
    r = 20'h0;
    for (int i = 0; i < 5; i++) begin
      c = s[i];
      r[4*(4-i) +: 4] = 4'(c - 8'd48);
    end
    return r;
  endfunction

  // Scoreboard consumer: every done_tick must match the oldest accepted start.
  always @(negedge clk) begin
    if (!reset && done_tick) begin
      sb_t e;
      n_done++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done_tick", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("bcd_result", 32'(bcd), 32'(e.exp));
        chk("latency", 32'(cyc - e.start_cyc + 1), 32'(LAT));
      end
    end
  end

  // Wait (at negedges) for ready; a timeout counts as a failure.
  task automatic wait_ready(input int budget);
    int k;
    k = 0;
    while (!ready && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!ready) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // Drive start for one cycle at the current (idle) negedge and record the expectation.
  task automatic launch(input logic [15:0] v, input logic [19:0] exp);
    bin   = v;
    start = 1'b1;
    sb_q.push_back('{exp: exp, start_cyc: cyc + 1});
    n_push++;
  endtask

  // Full conversion: launch, scramble bin after capture, count ready-low cycles.
  task automatic run_conv(input logic [15:0] v, input logic [19:0] exp);
    int low;
    wait_ready(60);
    launch(v, exp);
    @(negedge clk);
    start = 1'b0;
    bin   = 16'($urandom);
    low = 0;
    while (!ready && low < 60) begin
      low++;
      @(negedge clk);
    end
    chk("ready_low_cycles", 32'(low), 32'(LAT));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{bin: 16'd0,     exp: 20'h00000};
    vecs[1] = '{bin: 16'hFFFF,  exp: 20'h65535};
    vecs[2] = '{bin: 16'd46368, exp: 20'h46368};
    vecs[3] = '{bin: 16'd9999,  exp: 20'h09999};
    vecs[4] = '{bin: 16'd1,     exp: 20'h00001};
    vecs[5] = '{bin: 16'd10000, exp: 20'h10000};
    vecs[6] = '{bin: 16'd32768, exp: 20'h32768};
    vecs[7] = '{bin: 16'd99,    exp: 20'h00099};

    reset = 1'b1;
    start = 1'b0;
    bin   = 16'h0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_done_tick", 32'(done_tick), 32'd0);
    chk("reset_bcd", 32'(bcd), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(ready), 32'd1);

    // Table-driven vectors (bin=0 first covers the basic latency case).
    for (int i = 0; i < 8; i++) run_conv(vecs[i].bin, vecs[i].exp);

    // Back-to-back: start in the idle cycle right after done.
    wait_ready(60);
    launch(16'd46368, 20'h46368);
    @(negedge clk);
    start = 1'b0;
    while (!done_tick && cyc < 100000) @(negedge clk);
    @(negedge clk);
    chk("idle_after_done", 32'(ready), 32'd1);
    launch(16'd9, 20'h00009);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      chk("bcd_zero_during_op", 32'(bcd), 32'd0);
      @(negedge clk);
    end
    wait_ready(60);

    // Held start, bin changed during op: one result, then the held start restarts.
    launch(16'd100, 20'h00100);
    repeat (4) @(negedge clk);
    bin = 16'h1234;
    chk("start_ignored_busy", 32'(ready), 32'd0);
    while (!done_tick && cyc < 100000) @(negedge clk);
    @(negedge clk);
    chk("held_start_idle", 32'(ready), 32'd1);
    sb_q.push_back('{exp: 20'h04660, start_cyc: cyc + 1});
    n_push++;
    @(negedge clk);
    start = 1'b0;
    wait_ready(60);

    // Reset in op iteration 8 of 12345, then a clean conversion of 1234.
    launch(16'd12345, 20'h12345);
    void'(sb_q.pop_back());
    n_push--;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_done_tick", 32'(done_tick), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_stays_idle", 32'(ready), 32'd1);
    run_conv(16'd1234, 20'h01234);

    // Randomised sweep against the decimal-string reference.
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] v;
      v = 16'($urandom_range(0, 65535));
      run_conv(v, ref_bcd(v));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    chk("done_count", 32'(n_done), 32'(n_push));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bin2bcd_conv
